// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
//   sb_entry_t     : one in-flight destination {valid, rd, is_load}
//   FWD_RF         : forwarding select value meaning "use register file"
//   PIPE_DEPTH_MIN/MAX : legal scoreboard depth range
// The rd field is sized for the widest supported register address.
// Narrower addresses are zero-extended on entry and on compare.
package hazard_pkg;

  localparam int SB_RD_W        = 8;
  localparam int PIPE_DEPTH_MIN = 2;
  localparam int PIPE_DEPTH_MAX = 8;
  localparam int FWD_RF         = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage hazard bus between the ID controller
// (master) and the hazard scoreboard (slave).
//   ID side   : id_valid, rs1/rs2 (+used), rd, rd_write, is_load, branch_taken_ex
//   hazard side: pc_load, if_id_load, bubble, flush_if_id,
//                fwd_a_sel/fwd_b_sel, stall_cycles
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
);
  localparam int FWD_W = $clog2(PIPE_DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_used;
  logic              rs2_used;
  logic [REG_AW-1:0] rd;
  logic              rd_write;
  logic              is_load;
  logic              branch_taken_ex;
  logic              pc_load;
  logic              if_id_load;
  logic              bubble;
  logic              flush_if_id;
  logic [FWD_W-1:0]  fwd_a_sel;
  logic [FWD_W-1:0]  fwd_b_sel;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write, is_load,
           branch_taken_ex,
    input  pc_load, if_id_load, bubble, flush_if_id, fwd_a_sel, fwd_b_sel,
           stall_cycles
  );

  modport slave (
    input  id_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write, is_load,
           branch_taken_ex,
    output pc_load, if_id_load, bubble, flush_if_id, fwd_a_sel, fwd_b_sel,
           stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: compares one source register against the forwardable
// scoreboard entries (EX .. stage before WB) and priority-encodes the
// youngest match.
//   i_src, i_used : source address and "opcode reads it"
//   i_sb          : entries 0..PIPE_DEPTH-2 (WB excluded, RF is write-before-read)
//   o_hit         : some entry matches
//   o_load_hit    : youngest matching entry is a load
//   o_idx         : youngest match index + 1, FWD_RF when no match
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_W      = 2
) (
  input  logic [REG_AW-1:0]              i_src,
  input  logic                           i_used,
  input  sb_entry_t [PIPE_DEPTH-2:0]     i_sb,
  output logic                           o_hit,
  output logic                           o_load_hit,
  output logic [FWD_W-1:0]               o_idx
);

  logic w_src_ok;
  assign w_src_ok = i_used && (i_src != '0);

  // Walk oldest to youngest so the youngest match is written last.
  always_comb begin
    o_hit      = 1'b0;
    o_load_hit = 1'b0;
    o_idx      = FWD_W'(FWD_RF);
    for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
      if (w_src_ok && i_sb[k].valid && (i_sb[k].rd == SB_RD_W'(i_src))) begin
        o_hit      = 1'b1;
        o_load_hit = i_sb[k].is_load;
        o_idx      = FWD_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard unit. Shift-register scoreboard of
// in-flight destinations (entry 0 = EX .. PIPE_DEPTH-1 = WB), stall/bubble
// and taken-branch flush generation, optional forwarding selects and a
// saturating stall-cycle counter.
//   clock, reset : core clock, asynchronous active-high reset
//   bus          : hazard_scoreboard_if.slave (ID inputs, pipeline controls)
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   -> stall on load-use only, fwd selects report youngest match
//   undefined -> full interlock, fwd selects tied to register file
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int FWD_W = $clog2(PIPE_DEPTH + 1);

  if (PIPE_DEPTH < PIPE_DEPTH_MIN || PIPE_DEPTH > PIPE_DEPTH_MAX ||
      REG_AW > SB_RD_W) begin : g_bad_param
    $error("hazard_scoreboard: PIPE_DEPTH or REG_AW out of range");
  end

  sb_entry_t [PIPE_DEPTH-1:0] r_sb;
  sb_entry_t                  w_new;
  logic [CNT_W-1:0]           r_cnt;
  logic                       w_hit_a, w_hit_b;
  logic                       w_load_a, w_load_b;
  logic [FWD_W-1:0]           w_idx_a, w_idx_b;
  logic                       w_stall, w_flush, w_bubble;

  hazard_match #(.REG_AW(REG_AW), .PIPE_DEPTH(PIPE_DEPTH), .FWD_W(FWD_W)) u_match_a (
    .i_src      (bus.rs1),
    .i_used     (bus.rs1_used),
    .i_sb       (r_sb[PIPE_DEPTH-2:0]),
    .o_hit      (w_hit_a),
    .o_load_hit (w_load_a),
    .o_idx      (w_idx_a)
  );

  hazard_match #(.REG_AW(REG_AW), .PIPE_DEPTH(PIPE_DEPTH), .FWD_W(FWD_W)) u_match_b (
    .i_src      (bus.rs2),
    .i_used     (bus.rs2_used),
    .i_sb       (r_sb[PIPE_DEPTH-2:0]),
    .o_hit      (w_hit_b),
    .o_load_hit (w_load_b),
    .o_idx      (w_idx_b)
  );

`ifdef HAZARD_FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_stall = bus.id_valid &&
                   ((w_load_a && (w_idx_a == FWD_W'(1))) ||
                    (w_load_b && (w_idx_b == FWD_W'(1))));
  assign bus.fwd_a_sel = w_idx_a;
  assign bus.fwd_b_sel = w_idx_b;
  logic w_unused_sel;
  assign w_unused_sel = ^{w_hit_a, w_hit_b, r_sb[PIPE_DEPTH-1]};
`else
  assign w_stall = bus.id_valid && (w_hit_a || w_hit_b);
  assign bus.fwd_a_sel = FWD_W'(FWD_RF);
  assign bus.fwd_b_sel = FWD_W'(FWD_RF);
  logic w_unused_sel;
  assign w_unused_sel = ^{w_load_a, w_load_b, w_idx_a, w_idx_b, r_sb[PIPE_DEPTH-1]};
`endif

  // Flush dominates: the stalled instruction is on the wrong path anyway.
  assign w_flush         = bus.branch_taken_ex;
  assign w_bubble        = w_stall || w_flush;
  assign bus.bubble      = w_bubble;
  assign bus.flush_if_id = w_flush;
  assign bus.pc_load     = !w_stall || w_flush;
  assign bus.if_id_load  = !w_stall || w_flush;
  assign bus.stall_cycles = r_cnt;

  always_comb begin
    w_new = '0;
    if (!w_bubble) begin
      w_new.valid   = bus.id_valid && bus.rd_write && (bus.rd != '0);
      w_new.rd      = SB_RD_W'(bus.rd);
      w_new.is_load = bus.is_load;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sb <= '0;
    end else begin
      r_sb <= {r_sb[PIPE_DEPTH-2:0], w_new};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_stall && !w_flush && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against a list-based model of in-flight register writes. A second
// instance with a 2-bit counter covers saturation.
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int PD     = 3;
  localparam int CNT_W  = 16;
  localparam int CNT_W2 = 2;
  localparam int FWD_W  = $clog2(PD + 1);
  localparam int VW     = 4 + 2 * FWD_W + CNT_W;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .PIPE_DEPTH(PD), .CNT_W(CNT_W))  u_if ();
  hazard_scoreboard_if #(.REG_AW(REG_AW), .PIPE_DEPTH(PD), .CNT_W(CNT_W2)) u_if2 ();

  hazard_scoreboard #(.REG_AW(REG_AW), .PIPE_DEPTH(PD), .CNT_W(CNT_W)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  hazard_scoreboard #(.REG_AW(REG_AW), .PIPE_DEPTH(PD), .CNT_W(CNT_W2)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (u_if2.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // current ID inputs
  bit t_valid, t_u1, t_u2, t_w, t_ld, t_br;
  int t_rs1, t_rs2, t_rd;

  // model: list of in-flight writes, index 0 = EX
  bit m_v  [PD];
  int m_rd [PD];
  bit m_ld [PD];
  int m_cnt;

  // model outputs
  bit e_stall, e_flush, e_bubble;
  int e_fa, e_fb, e_cnt2;
  logic [VW-1:0] e_vec;
  logic [VW-1:0] obs_v;

  assign obs_v = {u_if.pc_load, u_if.if_id_load, u_if.bubble, u_if.flush_if_id,
                  u_if.fwd_a_sel, u_if.fwd_b_sel, u_if.stall_cycles};

  function automatic int youngest(int src, bit used);
    if (!used || src == 0) return 0;
    for (int k = 0; k <= PD - 2; k++)
      if (m_v[k] && m_rd[k] == src) return k + 1;
    return 0;
  endfunction

  function automatic void eval_model();
    int ya, yb;
    bit pl;
    ya = youngest(t_rs1, t_u1);
    yb = youngest(t_rs2, t_u2);
    if (FWD) begin
      e_stall = t_valid && m_ld[0] && (ya == 1 || yb == 1);
      e_fa = ya;
      e_fb = yb;
    end else begin
      e_stall = t_valid && (ya != 0 || yb != 0);
      e_fa = 0;
      e_fb = 0;
    end
    e_flush  = t_br;
    e_bubble = e_stall || e_flush;
    pl = !e_stall || e_flush;
    e_cnt2 = (m_cnt > 3) ? 3 : m_cnt;
    e_vec = {pl, pl, e_bubble, e_flush, FWD_W'(e_fa), FWD_W'(e_fb), CNT_W'(m_cnt)};
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < PD; k++) begin
      m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
    end
    m_cnt = 0;
  endfunction

  task automatic set_in(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit ld, bit br);
    t_valid = v; t_rs1 = rs1; t_u1 = u1; t_rs2 = rs2; t_u2 = u2;
    t_rd = rd; t_w = w; t_ld = ld; t_br = br;
    u_if.id_valid = v;  u_if2.id_valid = v;
    u_if.rs1 = REG_AW'(rs1); u_if2.rs1 = REG_AW'(rs1);
    u_if.rs2 = REG_AW'(rs2); u_if2.rs2 = REG_AW'(rs2);
    u_if.rs1_used = u1; u_if2.rs1_used = u1;
    u_if.rs2_used = u2; u_if2.rs2_used = u2;
    u_if.rd = REG_AW'(rd); u_if2.rd = REG_AW'(rd);
    u_if.rd_write = w; u_if2.rd_write = w;
    u_if.is_load = ld; u_if2.is_load = ld;
    u_if.branch_taken_ex = br; u_if2.branch_taken_ex = br;
    eval_model();
    #1;
  endtask

  // advance one clock; the model retires the oldest write and takes the new one
  task automatic tick();
    bit nv, st, fl, bb;
    eval_model();
    st = e_stall; fl = e_flush; bb = e_bubble;
    nv = !bb && t_valid && t_w && (t_rd != 0);
    @(posedge clock);
    #1;
    for (int k = PD - 1; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[0]  = nv;
    m_rd[0] = bb ? 0 : t_rd;
    m_ld[0] = bb ? 0 : t_ld;
    if (st && !fl && m_cnt < 65535) m_cnt++;
    eval_model();
  endtask

  task automatic idle(int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clock);
    #2;
    n_chk++; if (u_if.pc_load !== 1'b1) begin n_err++; $display("FAIL reset pc_load: got %b expected 1", u_if.pc_load); end
    n_chk++; if (u_if.if_id_load !== 1'b1) begin n_err++; $display("FAIL reset if_id_load: got %b expected 1", u_if.if_id_load); end
    n_chk++; if (u_if.bubble !== 1'b0) begin n_err++; $display("FAIL reset bubble: got %b expected 0", u_if.bubble); end
    n_chk++; if (u_if.flush_if_id !== 1'b0) begin n_err++; $display("FAIL reset flush: got %b expected 0", u_if.flush_if_id); end
    n_chk++; if (u_if.fwd_a_sel !== '0 || u_if.fwd_b_sel !== '0) begin n_err++; $display("FAIL reset fwd: got %0d/%0d expected 0/0", u_if.fwd_a_sel, u_if.fwd_b_sel); end
    n_chk++; if (u_if.stall_cycles !== '0) begin n_err++; $display("FAIL reset stall_cycles: got %0d expected 0", u_if.stall_cycles); end
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  // producer then consumer; returns observed stall cycles (bounded)
  task automatic run_pair(string nm, int prd, bit pld, int rs1, bit u1, int rs2, bit u2, output int stalls);
    bit done = 0;
    stalls = 0;
    set_in(1, 0, 0, 0, 0, prd, 1, pld, 0);
    n_chk++; if (obs_v !== e_vec) begin n_err++; $display("FAIL %s producer: got %h expected %h", nm, obs_v, e_vec); end
    tick();
    set_in(1, rs1, u1, rs2, u2, 20, 1, 0, 0);
    for (int c = 0; c < PD + 2; c++) begin
      n_chk++; if (obs_v !== e_vec) begin n_err++; $display("FAIL %s cyc%0d: got %h expected %h", nm, c, obs_v, e_vec); end
      if (u_if.bubble !== 1'b1) begin done = 1; break; end
      stalls++;
      tick();
    end
    n_chk++; if (!done) begin n_err++; $display("FAIL %s timeout: got %0d stall cycles expected fewer than %0d", nm, stalls, PD + 2); end
  endtask

  task automatic test_raw_stall();
    int st;
    logic [CNT_W-1:0] c0;
    idle(PD);
    c0 = u_if.stall_cycles;
    run_pair("raw_stall", 5, 0, 5, 1, 0, 0, st);
    n_chk++; if (st != (FWD ? 0 : 2)) begin n_err++; $display("FAIL raw_stall count: got %0d expected %0d", st, FWD ? 0 : 2); end
    n_chk++; if (u_if.stall_cycles - c0 !== CNT_W'(FWD ? 0 : 2)) begin n_err++; $display("FAIL raw_stall counter: got %0d expected %0d", u_if.stall_cycles - c0, FWD ? 0 : 2); end
    tick();
  endtask

  task automatic test_load_use();
    int st;
    idle(PD);
    run_pair("load_use", 6, 1, 6, 1, 6, 1, st);
    n_chk++; if (st != (FWD ? 1 : 2)) begin n_err++; $display("FAIL load_use count: got %0d expected %0d", st, FWD ? 1 : 2); end
    n_chk++; if (u_if.fwd_a_sel !== FWD_W'(FWD ? 2 : 0) || u_if.fwd_b_sel !== FWD_W'(FWD ? 2 : 0)) begin
      n_err++; $display("FAIL load_use fwd: got %0d/%0d expected %0d/%0d", u_if.fwd_a_sel, u_if.fwd_b_sel, FWD ? 2 : 0, FWD ? 2 : 0);
    end
    tick();
  endtask

  task automatic test_fwd_rs2();
    idle(PD);
    set_in(1, 0, 0, 0, 0, 8, 1, 0, 0);
    tick();
    set_in(1, 3, 1, 8, 1, 9, 1, 0, 0);
    n_chk++; if (u_if.bubble !== (FWD ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL fwd_rs2 bubble: got %b expected %b", u_if.bubble, !FWD); end
    n_chk++; if (u_if.fwd_b_sel !== FWD_W'(FWD ? 1 : 0) || u_if.fwd_a_sel !== '0) begin
      n_err++; $display("FAIL fwd_rs2 sel: got %0d/%0d expected 0/%0d", u_if.fwd_a_sel, u_if.fwd_b_sel, FWD ? 1 : 0);
    end
    n_chk++; if (obs_v !== e_vec) begin n_err++; $display("FAIL fwd_rs2 vec: got %h expected %h", obs_v, e_vec); end
    tick();
  endtask

  task automatic test_flush_over_stall();
    logic [CNT_W-1:0] c0;
    idle(PD);
    set_in(1, 0, 0, 0, 0, 9, 1, 1, 0);
    tick();
    c0 = u_if.stall_cycles;
    set_in(1, 9, 1, 0, 0, 10, 1, 0, 1);
    n_chk++; if ({u_if.pc_load, u_if.if_id_load, u_if.flush_if_id, u_if.bubble} !== 4'b1111) begin
      n_err++; $display("FAIL flush pl/ifid/fl/bub: got %b%b%b%b expected 1111", u_if.pc_load, u_if.if_id_load, u_if.flush_if_id, u_if.bubble);
    end
    tick();
    n_chk++; if (u_if.stall_cycles !== c0) begin n_err++; $display("FAIL flush counter: got %0d expected %0d", u_if.stall_cycles, c0); end
    set_in(1, 10, 1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (u_if.bubble !== 1'b0) begin n_err++; $display("FAIL flush bubble_entry: got %b expected 0", u_if.bubble); end
    tick();
  endtask

  task automatic test_x0();
    idle(PD);
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    set_in(1, 0, 1, 0, 1, 4, 1, 0, 0);
    n_chk++; if (u_if.bubble !== 1'b0 || u_if.fwd_a_sel !== '0 || u_if.fwd_b_sel !== '0) begin
      n_err++; $display("FAIL x0 bub/fwd: got %b/%0d/%0d expected 0/0/0", u_if.bubble, u_if.fwd_a_sel, u_if.fwd_b_sel);
    end
    tick();
  endtask

  task automatic test_saturation();
    int st;
    reset = 1'b1;
    model_clear();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      run_pair("sat", 11, 1, 11, 1, 0, 0, st);
      tick();
    end
    n_chk++; if (u_if2.stall_cycles !== 2'd3) begin n_err++; $display("FAIL sat cnt2: got %0d expected 3", u_if2.stall_cycles); end
    n_chk++; if (u_if.stall_cycles !== CNT_W'(FWD ? 5 : 10)) begin n_err++; $display("FAIL sat cnt16: got %0d expected %0d", u_if.stall_cycles, FWD ? 5 : 10); end
  endtask

  task automatic test_reset_mid_stall();
    idle(PD);
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    set_in(1, 5, 1, 0, 0, 12, 1, 0, 0);
    n_chk++; if (u_if.bubble !== 1'b1) begin n_err++; $display("FAIL midrst pre bubble: got %b expected 1", u_if.bubble); end
    reset = 1'b1;
    model_clear();
    #1;
    n_chk++; if ({u_if.pc_load, u_if.if_id_load, u_if.bubble, u_if.flush_if_id} !== 4'b1100 ||
                 u_if.fwd_a_sel !== '0 || u_if.stall_cycles !== '0 || u_if2.stall_cycles !== '0) begin
      n_err++; $display("FAIL midrst outputs: got %b%b%b%b fwd %0d cnt %0d/%0d expected 1100 fwd 0 cnt 0/0",
        u_if.pc_load, u_if.if_id_load, u_if.bubble, u_if.flush_if_id, u_if.fwd_a_sel, u_if.stall_cycles, u_if2.stall_cycles);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    eval_model();
    n_chk++; if (u_if.bubble !== 1'b0) begin n_err++; $display("FAIL midrst post bubble: got %b expected 0", u_if.bubble); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      n_chk++; if (obs_v !== e_vec) begin n_err++; $display("FAIL random cyc%0d: got %h expected %h", c, obs_v, e_vec); end
      n_chk++; if (u_if2.stall_cycles !== CNT_W2'(e_cnt2)) begin n_err++; $display("FAIL random cnt2 cyc%0d: got %0d expected %0d", c, u_if2.stall_cycles, e_cnt2); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_load_use();
    test_fwd_rs2();
    test_flush_over_stall();
    test_x0();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection unit for the decode stage of the pipelined RV32 core. It supersedes the fixed EX/MEM-only comparator. It keeps a shift-register scoreboard of in-flight destination registers covering every stage from EX to WB, and drives the PC/IF-ID load enables and the ID/EX bubble select. It also produces the taken-branch flush and, optionally, operand-forwarding selects, plus a stall-cycle counter. It sits beside the controller in ID and feeds the ID/EX register's bubble mux.

## Interface
Parameters:
- REG_AW, 5, register-address width
- PIPE_DEPTH, 3, scoreboard entries (entry 0 = EX … entry PIPE_DEPTH-1 = WB); legal range 2..8
- CNT_W, 16, width of the stall counter
- FWD_W, $clog2(PIPE_DEPTH+1), width of the forwarding selects (derived; not overridden)

Ports:
- clock  in  1  single core clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- rs1, rs2  in  REG_AW  source register addresses
- rs1_used, rs2_used  in  1  source actually read by the opcode
- rd  in  REG_AW  destination address
- rd_write  in  1  instruction writes rd
- is_load  in  1  instruction is a load
- branch_taken_ex  in  1  branch in EX resolved taken
- pc_load  out  1  PC register load enable
- if_id_load  out  1  IF/ID register load enable
- bubble  out  1  force ID/EX control fields to 0
- flush_if_id  out  1  invalidate IF/ID contents
- fwd_a_sel, fwd_b_sel  out  FWD_W  0 = register file, k = scoreboard entry k-1
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard entry: {valid, rd, is_load}. Every clock all entries shift one position toward WB; the WB entry is discarded.
- Entry 0 loads {id_valid & rd_write & (rd≠0), rd, is_load} when the ID instruction issues. It loads all-zero when `bubble` = 1.
- Source match: a source matches when it is used, its address is ≠0, and a valid entry has an equal rd. Priority goes to the youngest entry (lowest index).
- The register file is write-before-read, so the WB entry never causes a stall.
- stall = id_valid & any source matches entries 0..PIPE_DEPTH-2. This applies without forwarding; see Configuration for the forwarding case.
- flush = branch_taken_ex. Flush wins over stall.
- pc_load = if_id_load = ~stall | flush.
- bubble = stall | flush.
- flush_if_id = flush.
- stall_cycles increments on each cycle with stall & ~flush and saturates at all-ones.

## Timing
- Stall, bubble, flush and forwarding selects are combinational from the current scoreboard and the ID inputs: zero-cycle latency.
- The scoreboard and counter update on the rising edge of `clock`.
- Reset (asynchronous, mid-operation included) clears every entry and the counter immediately. With id_valid = 0 after reset, outputs are: pc_load = 1, if_id_load = 1, bubble = 0, flush_if_id = 0, fwd selects = 0, stall_cycles = 0.
- A stalled instruction re-evaluates each cycle as the producer advances. The stall lasts at most PIPE_DEPTH-1 cycles without forwarding, and exactly 1 cycle for load-use with forwarding.
- Flush and stall in the same cycle: flush only, the counter does not increment, and entry 0 gets a bubble.
- rd = 0 never enters the scoreboard as valid.

## Configuration
- Macro HAZARD_FORWARD_EN.
- Defined:
  - stall occurs only when a source matches entry 0 with is_load = 1 (load-use).
  - fwd_a_sel/fwd_b_sel = index+1 of the youngest matching entry in 0..PIPE_DEPTH-2, else 0.
- Undefined:
  - full-interlock stall as stated in Operation.
  - fwd selects are tied to 0.

## Structure
- Package hazard_pkg holds:
  - the scoreboard-entry packed struct
  - the FWD_RF = 0 constant
  - the PIPE_DEPTH legality check constants
- Sub-module hazard_match is instantiated once per source (×2). Inputs: one source plus the scoreboard vector. Outputs: hit, load_hit and the youngest-match index (priority encoder).

## Test plan
- Reset asserted mid-stall with entry 0 = {1, x5, load} → all outputs at reset values within the same cycle; after release, an instruction reading x5 does not stall.
- PIPE_DEPTH=3, no macro: add x5 issued, then add reading x5 → stall for 2 cycles, bubble = 1 both cycles, stall_cycles = 2, then issue.
- HAZARD_FORWARD_EN: lw x6 then add x7,x6,x6 → 1 stall cycle, then fwd_a_sel = fwd_b_sel = 2 (MEM entry).
- HAZARD_FORWARD_EN: add x8 then sub reading x8 as rs2 → no stall, fwd_b_sel = 1, fwd_a_sel = 0.
- Stall pending and branch_taken_ex = 1 in the same cycle → pc_load = 1, flush_if_id = 1, bubble = 1, counter unchanged.
- Instruction writing x0, followed by a reader of x0 → no stall, fwd selects 0. CNT_W=2 with 5 stall cycles → stall_cycles = 3.
